intr_ctrl: RTL

- Multi-source interrupt controller between N peripheral interrupt lines and the CPU's single intr/int_ack pair.
- Edge-detects and latches source requests, masks them, and selects one winner.
- Drives intr, completes the int_ack handshake, and holds the serviced source ID until the ISR writes end-of-interrupt (EOI).
- Memory-mapped on the IO bus (io_cs/io_rd/io_wr, Address[11:0], 32-bit data), sharing the DY read bus with the IO memory.

---
 rtl/intr_ctrl_pkg.sv | 23 ++
 rtl/intr_ctrl_if.sv | 11 +
 rtl/intr_prio_sel.sv | 31 +++
 rtl/intr_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/intr_ctrl_pkg.sv
// Shared constants and types for the intr_ctrl interrupt controller.
package intr_ctrl_pkg;

    // Register offsets within the 16-byte block (Address[3:0])
    localparam logic [3:0] OFF_MASK = 4'h0;
    localparam logic [3:0] OFF_PEND = 4'h4;
    localparam logic [3:0] OFF_VEC  = 4'h8;
    localparam logic [3:0] OFF_EOI  = 4'hC;

    // VECTOR register field positions
    localparam int VEC_ID_LSB     = 0;
    localparam int VEC_ID_W       = 5;
    localparam int VEC_ACTIVE_BIT = 8;
    localparam int VEC_LAST_LSB   = 24;
    localparam int VEC_LAST_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

endpackage

// File: rtl/intr_ctrl_if.sv
// Request side of the IO bus as seen by the interrupt controller register block.
interface intr_ctrl_if;
    logic        io_cs;
    logic        io_wr;
    logic        io_rd;
    logic [11:0] Address;
    logic [31:0] IO_in;

    modport master (output io_cs, io_wr, io_rd, Address, IO_in);
    modport slave  (input  io_cs, io_wr, io_rd, Address, IO_in);
endinterface

// File: rtl/intr_prio_sel.sv
// Combinational picker: first set bit of req scanning upward from start_idx with wrap-around.
module intr_prio_sel #(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] req,
    input  logic [4:0]       start_idx,
    output logic             valid,
    output logic [4:0]       id
);
    logic [31:0] req_ext;
    logic [4:0]  idx;

    assign req_ext = 32'(req);

    always_comb begin
        valid = 1'b0;
        id    = '0;
        idx   = '0;
        // Scan from the far end so the candidate nearest start_idx is written last and wins
        for (int i = N_SRC - 1; i >= 0; i--) begin
            idx = start_idx + 5'(i);
            if (idx >= 5'(N_SRC)) begin
                idx = idx - 5'(N_SRC);
            end
            if (req_ext[idx]) begin
                valid = 1'b1;
                id    = idx;
            end
        end
    end
endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-latched, maskable multi-source interrupt controller serving one source at a time.
// Build option INTC_ROUNDROBIN_EN: rotating priority starting after the last acknowledged source.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int          N_SRC     = 8,
    parameter logic [11:0] BASE_ADDR = 12'hF00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             int_ack,
    output logic             intr,
    intr_ctrl_if.slave       io,
    output logic [31:0]      IO_out
);
    state_t           state_reg, state_next;
    logic [N_SRC-1:0] mask_reg, pend_reg, irq_q_reg;
    logic [N_SRC-1:0] pend_next, rise, w1c, enabled;
    logic [4:0]       vec_id_reg;
    logic             active_reg;
    logic             hit, wr_en, rd_en;
    logic [3:0]       off;
    logic             sel_valid;
    logic [4:0]       sel_id, start_idx;
    logic             ack_take, eoi_wr;
    logic [31:0]      vec_word, rd_data;
    logic             unused_wdata;

    assign hit   = io.io_cs && (io.Address[11:4] == BASE_ADDR[11:4]);
    assign wr_en = hit && io.io_wr;
    assign rd_en = hit && io.io_rd && !io.io_wr;
    assign off   = io.Address[3:0];
    assign unused_wdata = ^io.IO_in[31:N_SRC];

    assign enabled  = pend_reg & mask_reg;
    assign w1c      = (wr_en && off == OFF_PEND) ? io.IO_in[N_SRC-1:0] : '0;
    assign ack_take = (state_reg == REQ) && int_ack && sel_valid;
    assign eoi_wr   = (state_reg == SVC) && wr_en && (off == OFF_EOI);

    // A new edge outranks both the W1C clear and the ack clear of the same bit
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        assign rise[gi]      = irq_src[gi] & ~irq_q_reg[gi];
        assign pend_next[gi] = rise[gi]
                             | (pend_reg[gi] & ~w1c[gi] & ~(ack_take && sel_id == 5'(gi)));
    end

`ifdef INTC_ROUNDROBIN_EN
    logic [4:0] last_id_reg;

    assign start_idx = (last_id_reg == 5'(N_SRC - 1)) ? 5'd0 : last_id_reg + 5'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_id_reg <= '0;
        end else if (ack_take) begin
            last_id_reg <= sel_id;
        end
    end
`else
    assign start_idx = 5'd0;
`endif

    intr_prio_sel #(.N_SRC(N_SRC)) u_sel (
        .req       (enabled),
        .start_idx (start_idx),
        .valid     (sel_valid),
        .id        (sel_id)
    );

    always_comb begin
        state_next = state_reg;
        intr       = 1'b0;
        case (state_reg)
            IDLE: if (|enabled) state_next = REQ;
            REQ: begin
                intr = 1'b1;
                if (!sel_valid)   state_next = IDLE;
                else if (int_ack) state_next = SVC;
            end
            SVC:     if (eoi_wr) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // irq_q follows the line even during reset so a level held across reset is not a new edge
        irq_q_reg <= irq_src;
        if (reset) begin
            state_reg  <= IDLE;
            mask_reg   <= '0;
            pend_reg   <= '0;
            vec_id_reg <= '0;
            active_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            if (wr_en && off == OFF_MASK) begin
                mask_reg <= io.IO_in[N_SRC-1:0];
            end
            if (ack_take) begin
                vec_id_reg <= sel_id;
                active_reg <= 1'b1;
            end else if (eoi_wr) begin
                active_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        vec_word = '0;
        vec_word[VEC_ID_LSB +: VEC_ID_W] = vec_id_reg;
        vec_word[VEC_ACTIVE_BIT]         = active_reg;
`ifdef INTC_ROUNDROBIN_EN
        vec_word[VEC_LAST_LSB +: VEC_LAST_W] = 8'(last_id_reg);
`endif
    end

    always_comb begin
        rd_data = '0;
        case (off)
            OFF_MASK: rd_data = 32'(mask_reg);
            OFF_PEND: rd_data = 32'(pend_reg);
            OFF_VEC:  rd_data = vec_word;
            default:  rd_data = '0;
        endcase
    end

    // Shared read bus: only drive it while this block is being read
    assign IO_out = rd_en ? rd_data : 32'bz;

endmodule
